dmem_arbiter: RTL and testbench

Two-requester arbiter sharing the single-port synchronous data memory between the core's load/store port (port 0) and a secondary master such as a DMA or debug loader (port 1). Every cycle it grants at most one request with a valid/ready handshake, drives the memory address, write data and byte-enables, and routes the one-cycle-late read data back to the requester that issued the read. It sits between the core's memory stage and the data memory instance.

---
 rtl/dmem_arbiter_if.sv | 23 ++
 rtl/dmem_arbiter.sv | 135 +++++++++++++
 tb/tb_dmem_arbiter.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Request-side bus of the data memory arbiter: one instance per requester.
// The master drives the request; the arbiter (slave) returns ready and read data.
interface dmem_arbiter_if #(
  parameter int ADDR_WIDTH = 14
) ();
  logic                  valid;
  logic                  ready;
  logic [ADDR_WIDTH-1:0] addr;
  logic [31:0]           wdata;
  logic [3:0]            wstrb;
  logic                  rvalid;
  logic [31:0]           rdata;

  modport master (
    output valid, addr, wdata, wstrb,
    input  ready, rvalid, rdata
  );

  modport slave (
    input  valid, addr, wdata, wstrb,
    output ready, rvalid, rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port synchronous data memory.
// Define DMEM_ARB_RR_EN for round-robin contention; default is port-0 priority with a starvation guard.
module dmem_arbiter #(
  parameter int ADDR_WIDTH   = 14,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  dmem_arbiter_if.slave         req0,
  dmem_arbiter_if.slave         req1,
  output logic [ADDR_WIDTH-1:0] mem_adra,
  output logic [31:0]           mem_dina,
  output logic [3:0]            mem_wea,
  input  logic [31:0]           mem_douta
);

  logic grant0;
  logic grant1;
  logic win1;
  logic rd_pend_q;
  logic rd_pend_d;
  logic rd_owner_q;
  logic rd_owner_d;

`ifdef DMEM_ARB_RR_EN
  logic last_grant_q;
  logic last_grant_d;

  // The port that did not win last time takes a contested cycle.
  assign win1 = (last_grant_q == 1'b0);

  always_comb begin
    last_grant_d = last_grant_q;
    if (grant0) begin
      last_grant_d = 1'b0;
    end else if (grant1) begin
      last_grant_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`else
  localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);

  logic [7:0] starve_cnt_q;
  logic [7:0] starve_cnt_d;

  assign win1 = (starve_cnt_q == STARVE_MAX);

  // Counts consecutive refused cycles of port 1, holding once the limit is reached.
  always_comb begin
    starve_cnt_d = '0;
    if (req1.valid && !grant1) begin
      if (starve_cnt_q == STARVE_MAX) begin
        starve_cnt_d = starve_cnt_q;
      end else begin
        starve_cnt_d = starve_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end
`endif

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!reset) begin
      if (req0.valid && req1.valid) begin
        grant1 = win1;
        grant0 = !win1;
      end else begin
        grant0 = req0.valid;
        grant1 = req1.valid;
      end
    end
  end

  assign req0.ready = grant0;
  assign req1.ready = grant1;

  // Idle cycles still present port 0's address so the memory port is never undriven.
  always_comb begin
    mem_adra = req0.addr;
    mem_dina = req0.wdata;
    mem_wea  = 4'b0000;
    if (grant1) begin
      mem_adra = req1.addr;
      mem_dina = req1.wdata;
      mem_wea  = req1.wstrb;
    end else if (grant0) begin
      mem_wea  = req0.wstrb;
    end
  end

  always_comb begin
    rd_pend_d  = 1'b0;
    rd_owner_d = rd_owner_q;
    if (grant0 && req0.wstrb == 4'b0000) begin
      rd_pend_d  = 1'b1;
      rd_owner_d = 1'b0;
    end else if (grant1 && req1.wstrb == 4'b0000) begin
      rd_pend_d  = 1'b1;
      rd_owner_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_pend_q  <= 1'b0;
      rd_owner_q <= 1'b0;
    end else begin
      rd_pend_q  <= rd_pend_d;
      rd_owner_q <= rd_owner_d;
    end
  end

  assign req0.rvalid = rd_pend_q && (rd_owner_q == 1'b0);
  assign req1.rvalid = rd_pend_q && (rd_owner_q == 1'b1);
  assign req0.rdata  = mem_douta;
  assign req1.rdata  = mem_douta;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: a word-level memory model predicts grants and read
// responses; a separate monitor checks every response the DUT presents.
module tb_dmem_arbiter;

  localparam int AW     = 14;
  localparam int STARVE = 8;

  typedef struct {
    int          due;
    bit          port;
    logic [31:0] data;
  } resp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] mem_adra;
  logic [31:0]   mem_dina;
  logic [3:0]    mem_wea;
  logic [31:0]   mem_douta;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  resp_t       exp_q[$];
  logic [31:0] shadow [int];
  logic [31:0] mem_arr [int];
  int          refused = 0;
  int          last_g  = 1;

  dmem_arbiter_if #(.ADDR_WIDTH(AW)) req0_if ();
  dmem_arbiter_if #(.ADDR_WIDTH(AW)) req1_if ();

  dmem_arbiter #(
    .ADDR_WIDTH(AW),
    .STARVE_LIMIT(STARVE)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req0(req0_if),
    .req1(req1_if),
    .mem_adra(mem_adra),
    .mem_dina(mem_dina),
    .mem_wea(mem_wea),
    .mem_douta(mem_douta)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Single-port synchronous memory: read-before-write, output cleared by reset.
  always @(posedge clk) begin
    logic [31:0] old_word;
    logic [31:0] new_word;
    old_word = mem_arr.exists(int'(mem_adra)) ? mem_arr[int'(mem_adra)] : 32'h0;
    new_word = old_word;
    for (int b = 0; b < 4; b++) begin
      if (mem_wea[b]) new_word[b*8 +: 8] = mem_dina[b*8 +: 8];
    end
    if (reset) begin
      mem_douta <= 32'h0;
    end else begin
      mem_douta <= old_word;
      if (mem_wea != 4'b0000) mem_arr[int'(mem_adra)] = new_word;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got %h, want %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Drives one cycle of requests, then predicts and checks the grant and memory bus.
  task automatic applyStimulus(input bit rst,
                               input bit v0, input logic [AW-1:0] a0, input logic [31:0] d0, input logic [3:0] s0,
                               input bit v1, input logic [AW-1:0] a1, input logic [31:0] d1, input logic [3:0] s1);
    int          g;
    logic [AW-1:0] ga;
    logic [31:0] gd;
    logic [3:0]  gs;
    logic [31:0] word;
    resp_t       r;
    reset         = rst;
    req0_if.valid = v0;
    req0_if.addr  = a0;
    req0_if.wdata = d0;
    req0_if.wstrb = s0;
    req1_if.valid = v1;
    req1_if.addr  = a1;
    req1_if.wdata = d1;
    req1_if.wstrb = s1;
    @(negedge clk);
    g = -1;
    if (!rst) begin
      if (v0 && v1) begin
`ifdef DMEM_ARB_RR_EN
        g = (last_g == 0) ? 1 : 0;
`else
        g = (refused >= STARVE) ? 1 : 0;
`endif
      end else if (v0) begin
        g = 0;
      end else if (v1) begin
        g = 1;
      end
    end
    ga = (g == 1) ? a1 : a0;
    gd = (g == 1) ? d1 : d0;
    gs = (g == 1) ? s1 : ((g == 0) ? s0 : 4'b0000);
    checkOutput("ready0", {31'b0, req0_if.ready}, {31'b0, g == 0});
    checkOutput("ready1", {31'b0, req1_if.ready}, {31'b0, g == 1});
    checkOutput("mem_wea", {28'b0, mem_wea}, {28'b0, gs});
    checkOutput("mem_adra", {18'b0, mem_adra}, {18'b0, ga});
    checkOutput("mem_dina", mem_dina, gd);
    if (g >= 0) begin
      word = shadow.exists(int'(ga)) ? shadow[int'(ga)] : 32'h0;
      if (gs == 4'b0000) begin
        r.due  = cyc + 1;
        r.port = (g == 1);
        r.data = word;
        exp_q.push_back(r);
      end else begin
        for (int b = 0; b < 4; b++) begin
          if (gs[b]) word[b*8 +: 8] = gd[b*8 +: 8];
        end
        shadow[int'(ga)] = word;
      end
    end
    if (rst) begin
      refused = 0;
      last_g  = 1;
    end else begin
      if (g >= 0) last_g = g;
      if (v1 && g != 1) refused = (refused + 1 > STARVE) ? STARVE : refused + 1;
      else refused = 0;
    end
    @(posedge clk);
    #1;
  endtask

  // Response monitor: every rvalid must match the oldest outstanding read due this cycle.
  always @(negedge clk) begin
    resp_t e;
    bit    r0;
    bit    r1;
    r0 = (req0_if.rvalid === 1'b1);
    r1 = (req1_if.rvalid === 1'b1);
    if (cyc > 0) begin
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        e = exp_q.pop_front();
        checkOutput(e.port ? "rvalid1" : "rvalid0", {31'b0, e.port ? r1 : r0}, 32'd1);
        checkOutput(e.port ? "rvalid0_idle" : "rvalid1_idle", {31'b0, e.port ? r0 : r1}, 32'd0);
        checkOutput(e.port ? "rdata1" : "rdata0", e.port ? req1_if.rdata : req0_if.rdata, e.data);
      end else if (r0 || r1) begin
        checkOutput("rvalid_unexpected", {30'b0, r1, r0}, 32'd0);
      end
    end
  end

  initial begin
    bit            rv0;
    bit            rv1;
    logic [AW-1:0] ra0;
    logic [AW-1:0] ra1;
    logic [3:0]    rs0;
    logic [3:0]    rs1;
    reset = 1'b1;
    req0_if.valid = 1'b0; req0_if.addr = '0; req0_if.wdata = '0; req0_if.wstrb = '0;
    req1_if.valid = 1'b0; req1_if.addr = '0; req1_if.wdata = '0; req1_if.wstrb = '0;
    @(posedge clk);
    #1;
    applyStimulus(1, 1, 14'h10, 32'h1, 4'hF, 1, 14'h11, 32'h2, 4'h0);
    applyStimulus(1, 0, 14'h0, 32'h0, 4'h0, 0, 14'h0, 32'h0, 4'h0);
    checkOutput("rvalid_reset", {30'b0, req1_if.rvalid, req0_if.rvalid}, 32'd0);

    applyStimulus(0, 1, 14'h10, 32'hDEADBEEF, 4'hF, 0, 14'h0, 32'h0, 4'h0);
    applyStimulus(0, 1, 14'h10, 32'h0, 4'h0, 0, 14'h0, 32'h0, 4'h0);
    applyStimulus(0, 0, 14'h0, 32'h0, 4'h0, 0, 14'h0, 32'h0, 4'h0);

    applyStimulus(0, 0, 14'h0, 32'h0, 4'h0, 1, 14'h20, 32'h11223344, 4'hF);
    applyStimulus(0, 0, 14'h0, 32'h0, 4'h0, 1, 14'h20, 32'h0000AA00, 4'b0010);
    applyStimulus(0, 0, 14'h0, 32'h0, 4'h0, 1, 14'h20, 32'h0, 4'h0);
    applyStimulus(0, 0, 14'h0, 32'h0, 4'h0, 0, 14'h0, 32'h0, 4'h0);

    for (int i = 0; i < 20; i++) begin
      applyStimulus(0, 1, 14'h10, 32'h0, 4'h0, 1, 14'h20, 32'h0, 4'h0);
    end

    applyStimulus(0, 1, 14'h30, 32'hA5A5_0030, 4'hF, 0, 14'h0, 32'h0, 4'h0);
    applyStimulus(0, 0, 14'h0, 32'h0, 4'h0, 1, 14'h31, 32'h5A5A_0031, 4'hF);
    applyStimulus(0, 1, 14'h30, 32'h0, 4'h0, 0, 14'h0, 32'h0, 4'h0);
    applyStimulus(0, 0, 14'h0, 32'h0, 4'h0, 1, 14'h31, 32'h0, 4'h0);
    applyStimulus(0, 1, 14'h30, 32'h0, 4'h0, 0, 14'h0, 32'h0, 4'h0);
    applyStimulus(0, 1, 14'h30, 32'hFFFF_FFFF, 4'hF, 0, 14'h0, 32'h0, 4'h0);

    applyStimulus(0, 1, 14'h10, 32'h0, 4'h0, 0, 14'h0, 32'h0, 4'h0);
    applyStimulus(1, 1, 14'h10, 32'h0, 4'h0, 1, 14'h20, 32'h0, 4'h0);
    checkOutput("rvalid_after_reset", {30'b0, req1_if.rvalid, req0_if.rvalid}, 32'd0);
    applyStimulus(0, 0, 14'h0, 32'h0, 4'h0, 0, 14'h0, 32'h0, 4'h0);

    for (int i = 0; i < 1800; i++) begin
      if (i < 300) begin
        rv0 = ($urandom_range(0, 9) < 9);
        rv1 = ($urandom_range(0, 9) < 9);
      end else begin
        rv0 = ($urandom_range(0, 9) < 6);
        rv1 = ($urandom_range(0, 9) < 6);
      end
      ra0 = AW'($urandom_range(0, 15));
      ra1 = AW'($urandom_range(0, 15));
      rs0 = ($urandom_range(0, 9) < 4) ? 4'h0 : 4'($urandom_range(1, 15));
      rs1 = ($urandom_range(0, 9) < 4) ? 4'h0 : 4'($urandom_range(1, 15));
      applyStimulus($urandom_range(0, 199) == 0, rv0, ra0, $urandom, rs0, rv1, ra1, $urandom, rs1);
    end
    applyStimulus(0, 0, 14'h0, 32'h0, 4'h0, 0, 14'h0, 32'h0, 4'h0);
    applyStimulus(0, 0, 14'h0, 32'h0, 4'h0, 0, 14'h0, 32'h0, 4'h0);
    checkOutput("queue_drained", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
